// File: rtl/seven_seg_pkg.sv
// Shared constants and BCD-to-segment decode for the seven-segment scan driver.
// All segment codes are active-low {a,b,c,d,e,f,g}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Codes 10..15 are not valid BCD and show a dash.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    return SEG_TABLE[bcd];
  endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero blank mask: bit i is set when digits i..NUM_DIGITS-1 are all zero.
// Digit 0 is never blanked; codes 10..15 count as non-zero.
module seven_seg_lz_mask #(
  parameter int NUM_DIGITS = 4,
  parameter int LZ_BLANK   = 1
) (
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   blank_mask
);

  logic upper_zero;

  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero    = upper_zero & (bcd[4*i +: 4] == 4'd0);
      blank_mask[i] = upper_zero & (LZ_BLANK != 0);
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadow capture, one digit
// per refresh slot, anode guard at slot start, global blank, leading-zero blanking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int GUARD_CYCLES     = 16,
  parameter int LZ_BLANK         = 1,
  parameter int ANODE_ACTIVE_LOW = 1,
  localparam int IDX_W = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int PS_W = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
  logic [PS_W-1:0]         prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic                    started_q, started_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic                    tick;
  logic                    anode_on;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blank_mask;

  seven_seg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .LZ_BLANK   (LZ_BLANK)
  ) u_lz_mask (
    .bcd        (shadow_q),
    .blank_mask (blank_mask)
  );

  always_comb begin
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    ptr_d       = ptr_q;
    digit_idx_d = digit_idx_q;
    started_d   = started_q;
    seg_d       = seg_q;
    dp_d        = dp_q;

    tick        = (prescaler_q == PS_W'(REFRESH_DIV - 1));
    prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);

    if (load) begin
      shadow_d    = bcd_in;
      dp_shadow_d = dp_in;
    end

    // Segment data comes from the pre-edge shadow, so a load on the tick edge
    // only shows up from the following tick.
    if (tick) begin
      digit_idx_d = ptr_q;
      ptr_d       = (ptr_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : ptr_q + IDX_W'(1);
      started_d   = 1'b1;
      seg_d       = blank_mask[ptr_q] ? SEG_OFF : bcd_to_seg7(shadow_q[4*ptr_q +: 4]);
      dp_d        = ~dp_shadow_q[ptr_q];
    end

    // Prescaler value after the edge equals cycles elapsed since the last tick.
    anode_on = started_d & ~blank_en & (prescaler_d >= PS_W'(GUARD_CYCLES));
    onehot   = NUM_DIGITS'(1) << digit_idx_d;
    if (anode_on) begin
      anode_d = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end else begin
      anode_d = ANODE_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      prescaler_q <= '0;
      ptr_q       <= '0;
      digit_idx_q <= '0;
      started_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      anode_q     <= ANODE_OFF;
    end else begin
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      prescaler_q <= prescaler_d;
      ptr_q       <= ptr_d;
      digit_idx_q <= digit_idx_d;
      started_q   <= started_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      anode_q     <= anode_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign anode     = anode_q;
  assign digit_idx = digit_idx_q;

endmodule
